led_sequencer: RTL and testbench

- Drives the board's 8 user LEDs with a selectable animated pattern instead of a fixed free-running counter.
- A programmable prescaler produces step strobes. A small control FSM accepts configuration (mode, step period) over a valid/ready handshake.
- Sits between board-level control logic (host register, button decoder) and the user_led pins.

---
 rtl/led_seq_pkg.sv | 37 +++
 rtl/led_sequencer_if.sv | 29 ++
 rtl/led_prescaler.sv | 35 +++
 rtl/led_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_led_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: mode and FSM encodings,
// per-mode initial patterns and the scan direction encoding.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [7:0] INIT_COUNT = 8'h00;
  localparam logic [7:0] INIT_SCAN  = 8'h01;
  localparam logic [7:0] INIT_BLINK = 8'h00;
  localparam logic [7:0] INIT_FILL  = 8'h00;

  localparam logic SCAN_UP   = 1'b0;
  localparam logic SCAN_DOWN = 1'b1;

  function automatic logic [7:0] init_pattern(input mode_e m);
    logic [7:0] p;
    case (m)
      MODE_COUNT: p = INIT_COUNT;
      MODE_SCAN:  p = INIT_SCAN;
      MODE_BLINK: p = INIT_BLINK;
      MODE_FILL:  p = INIT_FILL;
      default:    p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Configuration handshake bundle between the board control logic (master)
// and the LED sequencer (slave).
interface led_sequencer_if #(
  parameter int DIV_W = 24
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_bright;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_div,
    output cfg_bright,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_div,
    input  cfg_bright,
    output cfg_ready
  );

endinterface

// File: rtl/led_prescaler.sv
// Step-period prescaler: counts 0..div and flags the terminal count as a step.
// hold freezes the count; clr restarts it and suppresses the step.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count;
  logic             terminal;

  // >= rather than == so a count left above a newly shortened divider still wraps
  assign terminal = (count >= div);
  assign step     = terminal && !hold && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Animated pattern driver for the 8 user LEDs with a handshake-configured mode
// and step period. Define LED_PWM_EN to add 16-level brightness gating.
import led_seq_pkg::*;

module led_sequencer #(
  parameter int             DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd12_500_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  led_sequencer_if.slave        cfg,
  input  logic                  pause,
  output logic                  tick,
  output logic [1:0]            mode,
  output logic [7:0]            user_led
);

  state_e           state;
  state_e           state_next;
  logic             accept;
  logic             load;

  mode_e            mode_lat;
  logic [DIV_W-1:0] div_lat;
  mode_e            mode_q;
  logic [DIV_W-1:0] div_q;

  logic [7:0]       pattern;
  logic [7:0]       pattern_next;
  logic             scan_dir;
  logic             scan_dir_next;
  logic             step;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cfg.cfg_ready = 1'b0;
    accept        = 1'b0;
    load          = 1'b0;
    case (state)
      ST_RUN: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load       = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Accepted settings wait one cycle here and only take effect in LOAD
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_lat <= MODE_COUNT;
      div_lat  <= DEFAULT_DIV;
    end else if (accept) begin
      mode_lat <= mode_e'(cfg.cfg_mode);
      div_lat  <= cfg.cfg_div;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= MODE_COUNT;
      div_q  <= DEFAULT_DIV;
    end else if (load) begin
      mode_q <= mode_lat;
      div_q  <= div_lat;
    end
  end

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .clr  (load),
    .hold (pause),
    .div  (div_q),
    .step (step)
  );

  always_comb begin
    pattern_next  = pattern;
    scan_dir_next = scan_dir;
    case (mode_q)
      MODE_COUNT: pattern_next = pattern + 8'd1;
      MODE_SCAN: begin
        // Bounce at the ends so the bar never leaves the LED row
        if (scan_dir == SCAN_UP) begin
          if (pattern == 8'h80) begin
            pattern_next  = 8'h40;
            scan_dir_next = SCAN_DOWN;
          end else begin
            pattern_next = {pattern[6:0], 1'b0};
          end
        end else begin
          if (pattern == 8'h01) begin
            pattern_next  = 8'h02;
            scan_dir_next = SCAN_UP;
          end else begin
            pattern_next = {1'b0, pattern[7:1]};
          end
        end
      end
      MODE_BLINK: pattern_next = (pattern == 8'h00) ? 8'hFF : 8'h00;
      MODE_FILL:  pattern_next = (pattern == 8'hFF) ? 8'h00 : {pattern[6:0], 1'b1};
      default:    pattern_next = pattern;
    endcase
  end

  // LOAD takes priority so a restart always wins over a step in flight
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pattern  <= 8'h00;
      scan_dir <= SCAN_UP;
      tick     <= 1'b0;
    end else if (load) begin
      pattern  <= init_pattern(mode_lat);
      scan_dir <= SCAN_UP;
      tick     <= 1'b0;
    end else if (step) begin
      pattern  <= pattern_next;
      scan_dir <= scan_dir_next;
      tick     <= 1'b1;
    end else begin
      tick     <= 1'b0;
    end
  end

  assign mode = mode_q;

`ifdef LED_PWM_EN
  logic [3:0] bright_lat;
  logic [3:0] bright_q;
  logic [3:0] pwm_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bright_lat <= 4'hF;
    end else if (accept) begin
      bright_lat <= cfg.cfg_bright;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bright_q <= 4'hF;
      pwm_cnt  <= 4'h0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'h1;
      if (load) begin
        bright_q <= bright_lat;
      end
    end
  end

  assign user_led = pattern & {8{pwm_cnt <= bright_q}};
`else
  assign user_led = pattern;
`endif

  a_no_tick_after_load: assert property (
    @(posedge sys_clk) disable iff (sys_rst) (state == ST_LOAD) |=> !tick
  );

  a_scan_never_dark: assert property (
    @(posedge sys_clk) disable iff (sys_rst)
      (state == ST_RUN && mode_q == MODE_SCAN) |-> (pattern != 8'h00)
  );

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer; one task per scenario.
// Brightness expectations follow whether LED_PWM_EN is defined for the build.
module tb_led_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pause;
  logic       tick;
  logic [1:0] mode;
  logic [7:0] user_led;

  int checks   = 0;
  int failures = 0;

  led_sequencer_if #(.DIV_W(24)) cfg_if ();

  led_sequencer #(
    .DIV_W       (24),
    .DEFAULT_DIV (24'd12_500_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cfg      (cfg_if),
    .pause    (pause),
    .tick     (tick),
    .mode     (mode),
    .user_led (user_led)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of test sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents one configuration for a single cycle; returns with the DUT in LOAD
  task automatic handshake(input logic [1:0] m, input logic [23:0] d, input logic [3:0] b);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_mode   = m;
    cfg_if.cfg_div    = d;
    cfg_if.cfg_bright = b;
    next_cycle();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    int seen_tick;
    sys_rst           = 1'b1;
    pause             = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_mode   = 2'd0;
    cfg_if.cfg_div    = 24'd0;
    cfg_if.cfg_bright = 4'hF;
    repeat (3) next_cycle();
    sys_rst = 1'b0;
    checks++;
    if (user_led !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_led got=%h exp=%h", user_led, 8'h00);
    end
    checks++;
    if (tick !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_tick got=%b exp=0", tick);
    end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready);
    end
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("[TB] FAIL reset_mode got=%0d exp=0", mode);
    end
    seen_tick = 0;
    repeat (20) begin
      next_cycle();
      if (tick === 1'b1) seen_tick++;
    end
    checks++;
    if (seen_tick !== 0) begin
      failures++; $display("[TB] FAIL reset_idle_ticks got=%0d exp=0", seen_tick);
    end
  endtask

  task automatic test_count();
    handshake(2'd0, 24'd3, 4'hF);
    next_cycle();
    checks++;
    if (user_led !== 8'h00 || tick !== 1'b0) begin
      failures++; $display("[TB] FAIL count_init got=%h/%b exp=00/0", user_led, tick);
    end
    for (int k = 1; k <= 256; k++) begin
      for (int c = 1; c <= 4; c++) begin
        next_cycle();
        if (c < 4) begin
          checks++;
          if (tick !== 1'b0) begin
            failures++; $display("[TB] FAIL count_gap_tick k=%0d c=%0d got=%b exp=0", k, c, tick);
          end
        end else begin
          checks++;
          if (tick !== 1'b1 || user_led !== 8'(k)) begin
            failures++;
            $display("[TB] FAIL count_step k=%0d got=%h/%b exp=%h/1", k, user_led, tick, 8'(k));
          end
        end
      end
    end
    checks++;
    if (user_led !== 8'h00) begin
      failures++; $display("[TB] FAIL count_wrap got=%h exp=00", user_led);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_scan [16];
    exp_scan = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    handshake(2'd1, 24'd0, 4'hF);
    next_cycle();
    checks++;
    if (user_led !== 8'h01 || tick !== 1'b0 || mode !== 2'd1) begin
      failures++;
      $display("[TB] FAIL scan_init got=%h/%b/%0d exp=01/0/1", user_led, tick, mode);
    end
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      checks++;
      if (tick !== 1'b1 || user_led !== exp_scan[i]) begin
        failures++;
        $display("[TB] FAIL scan_step i=%0d got=%h/%b exp=%h/1", i, user_led, tick, exp_scan[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_fill [9];
    exp_fill = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL fill_ready_before got=%b exp=1", cfg_if.cfg_ready);
    end
    handshake(2'd3, 24'd1, 4'hF);
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_ready_drop got=%b exp=0", cfg_if.cfg_ready);
    end
    next_cycle();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || user_led !== 8'h00 || tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_init got=ready%b/%h/%b exp=ready1/00/0", cfg_if.cfg_ready, user_led, tick);
    end
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      checks++;
      if (tick !== 1'b0) begin
        failures++; $display("[TB] FAIL fill_gap_tick i=%0d got=%b exp=0", i, tick);
      end
      next_cycle();
      checks++;
      if (tick !== 1'b1 || user_led !== exp_fill[i]) begin
        failures++;
        $display("[TB] FAIL fill_step i=%0d got=%h/%b exp=%h/1", i, user_led, tick, exp_fill[i]);
      end
    end
  endtask

  task automatic test_blink_pause();
    handshake(2'd2, 24'd2, 4'hF);
    next_cycle();
    checks++;
    if (user_led !== 8'h00 || mode !== 2'd2) begin
      failures++; $display("[TB] FAIL blink_init got=%h/%0d exp=00/2", user_led, mode);
    end
    repeat (2) next_cycle();
    checks++;
    if (tick !== 1'b0) begin
      failures++; $display("[TB] FAIL blink_gap_tick got=%b exp=0", tick);
    end
    next_cycle();
    checks++;
    if (tick !== 1'b1 || user_led !== 8'hFF) begin
      failures++; $display("[TB] FAIL blink_first_step got=%h/%b exp=FF/1", user_led, tick);
    end
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      checks++;
      if (tick !== 1'b0 || user_led !== 8'hFF) begin
        failures++; $display("[TB] FAIL blink_paused i=%0d got=%h/%b exp=FF/0", i, user_led, tick);
      end
    end
    pause = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      checks++;
      if (tick !== 1'b0) begin
        failures++; $display("[TB] FAIL blink_resume_gap i=%0d got=%b exp=0", i, tick);
      end
    end
    next_cycle();
    checks++;
    if (tick !== 1'b1 || user_led !== 8'h00) begin
      failures++; $display("[TB] FAIL blink_resume_step got=%h/%b exp=00/1", user_led, tick);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) next_cycle();
    checks++;
    if (tick !== 1'b0 || user_led !== 8'h00) begin
      failures++; $display("[TB] FAIL b2b_pre got=%h/%b exp=00/0", user_led, tick);
    end
    handshake(2'd1, 24'd0, 4'hF);
    checks++;
    if (tick !== 1'b1 || user_led !== 8'hFF || mode !== 2'd2) begin
      failures++;
      $display("[TB] FAIL b2b_step got=%h/%b/%0d exp=FF/1/2", user_led, tick, mode);
    end
    next_cycle();
    checks++;
    if (tick !== 1'b0 || user_led !== 8'h01 || mode !== 2'd1) begin
      failures++;
      $display("[TB] FAIL b2b_load got=%h/%b/%0d exp=01/0/1", user_led, tick, mode);
    end
    next_cycle();
    checks++;
    if (tick !== 1'b1 || user_led !== 8'h02) begin
      failures++; $display("[TB] FAIL b2b_after got=%h/%b exp=02/1", user_led, tick);
    end
  endtask

  task automatic test_reset_mid_load();
    int bad;
    handshake(2'd2, 24'd0, 4'hF);
    #1;
    sys_rst = 1'b1;
    #1;
    checks++;
    if (user_led !== 8'h00 || mode !== 2'd0) begin
      failures++; $display("[TB] FAIL rst_load_out got=%h/%0d exp=00/0", user_led, mode);
    end
    checks++;
    if (tick !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_load_ctl got=tick%b/ready%b exp=tick0/ready1", tick, cfg_if.cfg_ready);
    end
    next_cycle();
    sys_rst = 1'b0;
    bad = 0;
    repeat (10) begin
      next_cycle();
      if (tick !== 1'b0 || user_led !== 8'h00 || mode !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("[TB] FAIL rst_discard bad_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_pwm();
    int on_cycles;
    int odd;
    int exp_on;
`ifdef LED_PWM_EN
    exp_on = 4;
`else
    exp_on = 16;
`endif
    handshake(2'd2, 24'd100, 4'h3);
    next_cycle();
    repeat (100) next_cycle();
    next_cycle();
    checks++;
    if (tick !== 1'b1) begin
      failures++; $display("[TB] FAIL pwm_tick got=%b exp=1", tick);
    end
    on_cycles = 0;
    odd = 0;
    repeat (16) begin
      next_cycle();
      if (user_led === 8'hFF) on_cycles++;
      else if (user_led !== 8'h00) odd++;
    end
    checks++;
    if (on_cycles !== exp_on) begin
      failures++; $display("[TB] FAIL pwm_duty got=%0d exp=%0d", on_cycles, exp_on);
    end
    checks++;
    if (odd !== 0) begin
      failures++; $display("[TB] FAIL pwm_levels partial_cycles got=%0d exp=0", odd);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_scan();
    test_fill();
    test_blink_pause();
    test_back_to_back();
    test_reset_mid_load();
    test_pwm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
